mem_access: RTL and testbench

Memory-access stage directly downstream of the execute stage. Consumes the execute stage's result bundle (aluop, effective address, store data, write-back info) and performs LoongArch LD/ST byte/half/word accesses over a req/ack data bus. Produces a registered bundle for write-back and stalls the upstream pipeline while a bus access is outstanding. Non-memory instructions pass through with one-cycle latency.

---
 rtl/mem_access_pkg.sv | 53 +++++
 rtl/mem_access_align.sv | 62 ++++++
 rtl/mem_access.sv | 170 +++++++++++++++++
 tb/tb_mem_access.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: aluop codes for the
// LoongArch LD/ST family, the ALE bit position in excepttype_o, FSM state
// encodings and small op-decoding helpers.
package mem_access_pkg;

  // Memory aluop codes (AluOpBus, 8 bits)
  localparam logic [7:0] LD_B  = 8'hE0;
  localparam logic [7:0] LD_H  = 8'hE1;
  localparam logic [7:0] LD_W  = 8'hE2;
  localparam logic [7:0] LD_BU = 8'hE3;
  localparam logic [7:0] LD_HU = 8'hE4;
  localparam logic [7:0] ST_B  = 8'hE8;
  localparam logic [7:0] ST_H  = 8'hE9;
  localparam logic [7:0] ST_W  = 8'hEA;

  // Address-misalignment flag position in excepttype_o
  localparam int unsigned ALE_BIT = 2;

  // FSM state encodings
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } acc_size_t;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == LD_B) || (op == LD_H) || (op == LD_W) ||
           (op == LD_BU) || (op == LD_HU);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == ST_B) || (op == ST_H) || (op == ST_W);
  endfunction

  function automatic logic is_signed_load(input logic [7:0] op);
    return (op == LD_B) || (op == LD_H);
  endfunction

  function automatic acc_size_t op_size(input logic [7:0] op);
    acc_size_t sz;
    case (op)
      LD_B, LD_BU, ST_B: sz = SZ_B;
      LD_H, LD_HU, ST_H: sz = SZ_H;
      default:           sz = SZ_W;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/mem_access_align.sv
// mem_align: combinational lane logic for the memory-access stage.
// Ports:
//   aluop      - operation code
//   addr_lo    - low two bits of the effective address
//   store_data - register value to be stored
//   rdata      - bus read word
//   is_mem     - aluop is a load or store
//   is_load    - aluop is a load
//   misaligned - H access at odd address, or W access not word aligned
//   be         - byte enables
//   wdata      - store data replicated across lanes
//   load_data  - extracted and sign/zero-extended load result
module mem_align
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic        is_mem,
  output logic        is_load,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  acc_size_t   size;
  logic        sext;
  logic [31:0] lane;

  always_comb begin
    size       = op_size(aluop);
    sext       = is_signed_load(aluop);
    is_load    = is_load_op(aluop);
    is_mem     = is_load || is_store_op(aluop);
    // Addressed byte/half moved down to bit 0
    lane       = rdata >> {addr_lo, 3'b000};
    be         = 4'b1111;
    wdata      = store_data;
    load_data  = rdata;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{sext & lane[7]}}, lane[7:0]};
      end
      SZ_H: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        load_data  = {{16{sext & lane[15]}}, lane[15:0]};
        misaligned = addr_lo[0];
      end
      default: begin
        misaligned = |addr_lo;
      end
    endcase
    misaligned = misaligned & is_mem;
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory-access pipeline stage. Registers the execute bundle for
// write-back; for aligned LD/ST ops issues one req/ack bus access and stalls
// upstream until the access completes.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   flush_i                  - kill the instruction in this stage
//   ex_valid_i .. excepttype_i - execute-stage result bundle
//   stallreq_o               - hold upstream while an access is outstanding
//   data_req_o .. data_wdata_o - bus request (held until data_ack_i)
//   data_ack_i, data_rdata_i - bus completion and read word
//   wb_valid_o .. excepttype_o - registered write-back bundle ({ALE, exc})
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              ex_valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic [31:0]       inst_pc_i,
  input  logic [1:0]        excepttype_i,
  output logic              stallreq_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_ack_i,
  input  logic [DATA_W-1:0] data_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [31:0]       inst_pc_o,
  output logic [2:0]        excepttype_o
);

  logic [1:0]  state;
  logic [7:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic        is_load_q;
  logic [31:0] pc_q;

  logic        idle;
  logic [7:0]  al_op;
  logic [1:0]  al_addr_lo;
  logic        al_is_mem;
  logic        al_is_load;
  logic        al_misaligned;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load_data;

  assign idle       = (state == S_IDLE);
  assign stallreq_o = !idle;

  // One align instance serves both phases: in IDLE it decodes the incoming
  // op for issue, otherwise the latched op for load extraction on ack.
  assign al_op      = idle ? aluop_i : op_q;
  assign al_addr_lo = idle ? mem_addr_i[1:0] : addr_lo_q;

  mem_align u_align (
    .aluop      (al_op),
    .addr_lo    (al_addr_lo),
    .store_data (reg2_i),
    .rdata      (data_rdata_i),
    .is_mem     (al_is_mem),
    .is_load    (al_is_load),
    .misaligned (al_misaligned),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      addr_lo_q    <= '0;
      wd_q         <= '0;
      wreg_q       <= 1'b0;
      is_load_q    <= 1'b0;
      pc_q         <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wd_o         <= '0;
      wreg_o       <= 1'b0;
      wdata_o      <= '0;
      inst_pc_o    <= '0;
      excepttype_o <= '0;
    end else begin
      wb_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ex_valid_i && !flush_i) begin
            if (!al_is_mem || (excepttype_i != '0)) begin
              wd_o         <= wd_i;
              wreg_o       <= wreg_i;
              wdata_o      <= wdata_i;
              inst_pc_o    <= inst_pc_i;
              excepttype_o <= {1'b0, excepttype_i};
              wb_valid_o   <= 1'b1;
            end else if (al_misaligned) begin
              wd_o                  <= wd_i;
              wreg_o                <= 1'b0;
              wdata_o               <= mem_addr_i;
              inst_pc_o             <= inst_pc_i;
              excepttype_o          <= {1'b0, excepttype_i};
              excepttype_o[ALE_BIT] <= 1'b1;
              wb_valid_o            <= 1'b1;
            end else begin
              op_q         <= aluop_i;
              addr_lo_q    <= mem_addr_i[1:0];
              wd_q         <= wd_i;
              wreg_q       <= wreg_i;
              is_load_q    <= al_is_load;
              pc_q         <= inst_pc_i;
              data_req_o   <= 1'b1;
              data_we_o    <= !al_is_load;
              data_be_o    <= al_be;
              data_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
              data_wdata_o <= al_wdata;
              state        <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (data_ack_i) begin
            data_req_o <= 1'b0;
            data_we_o  <= 1'b0;
            state      <= S_IDLE;
            if (!flush_i) begin
              wd_o         <= wd_q;
              wreg_o       <= is_load_q & wreg_q;
              if (is_load_q) wdata_o <= al_load_data;
              inst_pc_o    <= pc_q;
              excepttype_o <= '0;
              wb_valid_o   <= 1'b1;
            end
          end else if (flush_i) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (data_ack_i) begin
            data_req_o <= 1'b0;
            data_we_o  <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  import mem_access_pkg::*;

  localparam logic [7:0] OP_OR = 8'h25;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        ex_valid_i = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [4:0]  wd_i = '0;
  logic        wreg_i = 1'b0;
  logic [31:0] wdata_i = '0;
  logic [31:0] mem_addr_i = '0;
  logic [31:0] reg2_i = '0;
  logic [31:0] inst_pc_i = '0;
  logic [1:0]  excepttype_i = '0;
  logic        stallreq_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_ack_i = 1'b0;
  logic [31:0] data_rdata_i = '0;
  logic        wb_valid_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] inst_pc_o;
  logic [2:0]  excepttype_o;

  mem_access #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .ex_valid_i   (ex_valid_i),
    .aluop_i      (aluop_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .mem_addr_i   (mem_addr_i),
    .reg2_i       (reg2_i),
    .inst_pc_i    (inst_pc_i),
    .excepttype_i (excepttype_i),
    .stallreq_o   (stallreq_o),
    .data_req_o   (data_req_o),
    .data_we_o    (data_we_o),
    .data_be_o    (data_be_o),
    .data_addr_o  (data_addr_o),
    .data_wdata_o (data_wdata_o),
    .data_ack_i   (data_ack_i),
    .data_rdata_i (data_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .inst_pc_o    (inst_pc_o),
    .excepttype_o (excepttype_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [31:0] pc;
    logic [2:0]  exc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   wb_seen = 0;
  int   wb_expected = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                           input logic chk_wdata, input logic [31:0] pc, input logic [2:0] exc);
    exp_t e;
    e.wd = wd; e.wreg = wreg; e.wdata = wdata; e.chk_wdata = chk_wdata; e.pc = pc; e.exc = exc;
    sb.push_back(e);
    wb_expected++;
  endtask

  // Monitor: compares every write-back pulse against the scoreboard head
  always @(negedge clk) begin
    if (wb_valid_o) begin
      wb_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wb: got wb_valid_o=1 pc=0x%08h expected no write-back", inst_pc_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("wb_wd", 32'(wd_o), 32'(e.wd));
        check("wb_wreg", 32'(wreg_o), 32'(e.wreg));
        if (e.chk_wdata) check("wb_wdata", wdata_o, e.wdata);
        check("wb_pc", inst_pc_o, e.pc);
        check("wb_exc", 32'(excepttype_o), 32'(e.exc));
      end
    end
  end

  // Present one execute bundle for a single edge
  task automatic issue(input logic [7:0] op, input logic [4:0] wd, input logic wreg,
                       input logic [31:0] wdata, input logic [31:0] addr,
                       input logic [31:0] reg2, input logic [31:0] pc, input logic [1:0] exc);
    ex_valid_i = 1'b1; aluop_i = op; wd_i = wd; wreg_i = wreg; wdata_i = wdata;
    mem_addr_i = addr; reg2_i = reg2; inst_pc_i = pc; excepttype_i = exc;
    @(negedge clk);
    ex_valid_i = 1'b0; aluop_i = '0; excepttype_i = '0;
  endtask

  // Called at the first negedge after issue; holds ack low for 'delay'
  // edges, then pulses it, counting cycles with stallreq_o high.
  task automatic bus_ack(input int unsigned delay, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    for (int unsigned i = 0; i < delay; i++) begin
      if (stallreq_o) stalls++;
      @(negedge clk);
    end
    if (stallreq_o) stalls++;
    data_ack_i = 1'b1; data_rdata_i = rdata;
    @(negedge clk);
    data_ack_i = 1'b0; data_rdata_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int stalls;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    check("rst_req", 32'(data_req_o), 32'd0);
    check("rst_be", 32'(data_be_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_exc", 32'(excepttype_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Non-memory op passes through in one cycle
    expect_wb(5'd5, 1'b1, 32'h0000_00F0, 1'b1, 32'h100, 3'b000);
    issue(OP_OR, 5'd5, 1'b1, 32'h0000_00F0, 32'h0, 32'h0, 32'h100, 2'b00);
    check("or_no_req", 32'(data_req_o), 32'd0);
    check("or_no_stall", 32'(stallreq_o), 32'd0);
    @(negedge clk);

    // LD_B at byte 3, ack after three idle edges
    expect_wb(5'd6, 1'b1, 32'hFFFF_FF80, 1'b1, 32'h104, 3'b000);
    issue(LD_B, 5'd6, 1'b1, 32'h0, 32'h1003, 32'h0, 32'h104, 2'b00);
    check("ldb_req", 32'(data_req_o), 32'd1);
    check("ldb_we", 32'(data_we_o), 32'd0);
    check("ldb_be", 32'(data_be_o), 32'b1000);
    check("ldb_addr", data_addr_o, 32'h1000);
    bus_ack(3, 32'h80FF_1234, stalls);
    check("ldb_stall_cycles", 32'(stalls), 32'd4);
    check("ldb_req_drop", 32'(data_req_o), 32'd0);
    check("ldb_stall_drop", 32'(stallreq_o), 32'd0);

    // LD_BU same access: zero-extended
    expect_wb(5'd6, 1'b1, 32'h0000_0080, 1'b1, 32'h108, 3'b000);
    issue(LD_BU, 5'd6, 1'b1, 32'h0, 32'h1003, 32'h0, 32'h108, 2'b00);
    bus_ack(3, 32'h80FF_1234, stalls);

    // ST_H upper half, minimum latency
    expect_wb(5'd7, 1'b0, 32'h0, 1'b0, 32'h10C, 3'b000);
    issue(ST_H, 5'd7, 1'b1, 32'h0, 32'h2002, 32'h0000_ABCD, 32'h10C, 2'b00);
    check("sth_we", 32'(data_we_o), 32'd1);
    check("sth_be", 32'(data_be_o), 32'b1100);
    check("sth_wdata", data_wdata_o, 32'hABCD_ABCD);
    check("sth_addr", data_addr_o, 32'h2000);
    bus_ack(1, 32'h0, stalls);
    check("sth_stall_cycles", 32'(stalls), 32'd2);

    // ST_B replication
    expect_wb(5'd9, 1'b0, 32'h0, 1'b0, 32'h110, 3'b000);
    issue(ST_B, 5'd9, 1'b1, 32'h0, 32'h7001, 32'h1234_5655, 32'h110, 2'b00);
    check("stb_be", 32'(data_be_o), 32'b0010);
    check("stb_wdata", data_wdata_o, 32'h5555_5555);
    bus_ack(0, 32'h0, stalls);

    // LD_H upper half sign-extended, LD_HU lower half zero-extended
    expect_wb(5'd10, 1'b1, 32'hFFFF_8001, 1'b1, 32'h114, 3'b000);
    issue(LD_H, 5'd10, 1'b1, 32'h0, 32'h6002, 32'h0, 32'h114, 2'b00);
    check("ldh_be", 32'(data_be_o), 32'b1100);
    bus_ack(1, 32'h8001_7FFF, stalls);
    expect_wb(5'd11, 1'b1, 32'h0000_8001, 1'b1, 32'h118, 3'b000);
    issue(LD_HU, 5'd11, 1'b1, 32'h0, 32'h6000, 32'h0, 32'h118, 2'b00);
    check("ldhu_be", 32'(data_be_o), 32'b0011);
    bus_ack(2, 32'h7FFF_8001, stalls);

    // LD_W word load
    expect_wb(5'd12, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h11C, 3'b000);
    issue(LD_W, 5'd12, 1'b1, 32'h0, 32'h3004, 32'h0, 32'h11C, 2'b00);
    check("ldw_be", 32'(data_be_o), 32'b1111);
    bus_ack(1, 32'hDEAD_BEEF, stalls);

    // Misaligned LD_W and ST_H: ALE, no bus request
    expect_wb(5'd8, 1'b0, 32'h0000_3001, 1'b1, 32'h120, 3'b100);
    issue(LD_W, 5'd8, 1'b1, 32'h0, 32'h3001, 32'h0, 32'h120, 2'b00);
    check("ale_ldw_no_req", 32'(data_req_o), 32'd0);
    check("ale_ldw_no_stall", 32'(stallreq_o), 32'd0);
    expect_wb(5'd13, 1'b0, 32'h0000_6001, 1'b1, 32'h124, 3'b100);
    issue(ST_H, 5'd13, 1'b1, 32'h0, 32'h6001, 32'h0, 32'h124, 2'b00);
    check("ale_sth_no_req", 32'(data_req_o), 32'd0);

    // Upstream exception: pass through without bus access
    expect_wb(5'd14, 1'b1, 32'h0000_0055, 1'b1, 32'h128, 3'b001);
    issue(LD_W, 5'd14, 1'b1, 32'h0000_0055, 32'h4000, 32'h0, 32'h128, 2'b01);
    check("exc_no_req", 32'(data_req_o), 32'd0);
    @(negedge clk);

    // Flush in WAIT, ack two edges later: request held, nothing retired
    issue(LD_W, 5'd15, 1'b1, 32'h0, 32'h4000, 32'h0, 32'h12C, 2'b00);
    check("flw_req", 32'(data_req_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flw_req_held1", 32'(data_req_o), 32'd1);
    check("flw_stall_drain", 32'(stallreq_o), 32'd1);
    @(negedge clk);
    check("flw_req_held2", 32'(data_req_o), 32'd1);
    data_ack_i = 1'b1; data_rdata_i = 32'h1111_2222;
    @(negedge clk);
    data_ack_i = 1'b0; data_rdata_i = '0;
    check("flw_req_drop", 32'(data_req_o), 32'd0);
    check("flw_stall_drop", 32'(stallreq_o), 32'd0);

    // Flush together with ack: result dropped
    issue(LD_W, 5'd16, 1'b1, 32'h0, 32'h5000, 32'h0, 32'h130, 2'b00);
    flush_i = 1'b1; data_ack_i = 1'b1; data_rdata_i = 32'h3333_4444;
    @(negedge clk);
    flush_i = 1'b0; data_ack_i = 1'b0; data_rdata_i = '0;
    check("flack_req", 32'(data_req_o), 32'd0);
    check("flack_stall", 32'(stallreq_o), 32'd0);

    // Flush in IDLE kills the incoming bundle
    flush_i = 1'b1;
    issue(OP_OR, 5'd17, 1'b1, 32'hAAAA_0000, 32'h0, 32'h0, 32'h134, 2'b00);
    flush_i = 1'b0;

    // Stray ack in IDLE is ignored
    data_ack_i = 1'b1; data_rdata_i = 32'h5555_6666;
    @(negedge clk);
    data_ack_i = 1'b0; data_rdata_i = '0;
    check("stray_ack_req", 32'(data_req_o), 32'd0);
    check("stray_ack_stall", 32'(stallreq_o), 32'd0);

    // Reset during WAIT
    expect_wb(5'd18, 1'b1, 32'h0000_0077, 1'b1, 32'h138, 3'b000);
    issue(OP_OR, 5'd18, 1'b1, 32'h0000_0077, 32'h0, 32'h0, 32'h138, 2'b00);
    issue(LD_W, 5'd19, 1'b1, 32'h0, 32'h8000, 32'h0, 32'h13C, 2'b00);
    check("rstw_req", 32'(data_req_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstw_req_drop", 32'(data_req_o), 32'd0);
    check("rstw_stall", 32'(stallreq_o), 32'd0);
    check("rstw_wdata", wdata_o, 32'd0);
    check("rstw_pc", inst_pc_o, 32'd0);
    check("rstw_addr", data_addr_o, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Scoreboard drained and pulse count matches
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("wb_count", 32'(wb_seen), 32'(wb_expected));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
